// File: rtl/clock_div_controller_pkg.sv
// Shared constants for the clock divider controller: FSM state encoding and
// the smallest divisor the controller will accept.
package clock_div_controller_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StPend = 2'd2;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/div_counter.sv
// Period counter: counts 0..div-1 while enabled, wraps at terminal count,
// and can be cleared synchronously.
module div_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == (div - One));
  assign cnt = cnt_q;

  // Next count: clear wins, otherwise advance and wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tc ? '0 : (cnt_q + One);
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_div_controller.sv
// Programmable clock divider controller. A divisor offered while running is
// held as pending and committed only at the end of the current period, so a
// period is never truncated by reconfiguration.
module clock_div_controller
  import clock_div_controller_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic             div_out,
  output logic             running,
  output logic [WIDTH-1:0] cur_div
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             cfg_err_q, cfg_err_d;

  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             cnt_clear;
  logic             handshake;
  logic             legal;
  logic             accept;

  assign running   = (state_q != StIdle);
  assign cfg_ready = (state_q != StPend);
  assign handshake = cfg_valid & cfg_ready;
  assign legal     = (cfg_div >= WIDTH'(MIN_DIV));
  assign accept    = handshake & legal;

  // Outputs decode registered state only; no input reaches tick or div_out.
  assign tick    = running & tc;
  assign div_out = running & (cnt < (cur_div_q >> 1));
  assign cur_div = cur_div_q;
  assign cfg_err = cfg_err_q;

  div_counter #(
    .WIDTH (WIDTH)
  ) u_div_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (running),
    .div    (cur_div_q),
    .cnt    (cnt),
    .tc     (tc)
  );

  // FSM, divisor commit and handshake decode.
  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    cfg_err_d = handshake & ~legal;
    cnt_clear = 1'b0;
    case (state_q)
      StIdle: begin
        // Hold cnt at 0 so the first RUN cycle starts a fresh period.
        cnt_clear = 1'b1;
        if (accept) begin
          cur_div_d = cfg_div;
        end
        if (enable) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
          // Stopping anyway, so a new divisor can commit immediately.
          if (accept) begin
            cur_div_d = cfg_div;
          end
        end else if (accept) begin
          pend_d  = cfg_div;
          state_d = StPend;
        end
      end
      StPend: begin
        if (!enable) begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
          cur_div_d = pend_q;
        end else if (tc) begin
          // Counter wraps to 0 on this same edge, so the new period starts clean.
          cur_div_d = pend_q;
          state_d   = StRun;
        end
      end
      default: begin
        state_d   = StIdle;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cur_div_q <= WIDTH'(RESET_DIV);
      pend_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_clock_div_controller.sv
// Bench for clock_div_controller: a cycle model pushes expected outputs to a
// scoreboard as each cycle's stimulus is applied; each scenario task pops and
// compares after the edge, and adds hand-derived checks for its scenario.
module tb_clock_div_controller;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned RESET_DIV = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [WIDTH-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             tick;
  logic             div_out;
  logic             running;
  logic [WIDTH-1:0] cur_div;

  clock_div_controller #(
    .WIDTH     (WIDTH),
    .RESET_DIV (RESET_DIV)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .div_out   (div_out),
    .running   (running),
    .cur_div   (cur_div)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Packed view: {running, cfg_ready, cfg_err, tick, div_out, cur_div[7:0]}.
  logic [12:0] sb[$];
  logic [12:0] got;
  logic [12:0] exp_v;

  // Model state: ms 0=idle 1=run 2=pend.
  int ms, mc, md, mp;
  bit me;

  function automatic logic [12:0] obs();
    return {running, cfg_ready, cfg_err, tick, div_out, cur_div};
  endfunction

  // Advance the model with the inputs now applied, queue the expected
  // post-edge outputs, then move past the next rising edge.
  task automatic step();
    bit hs, ok, run;
    if (reset) begin
      ms = 0; mc = 0; md = RESET_DIV; mp = 0; me = 1'b0;
    end else begin
      hs = cfg_valid && (ms != 2);
      ok = hs && (cfg_div >= 2);
      me = hs && !ok;
      case (ms)
        0: begin
          if (ok) md = int'(cfg_div);
          mc = 0;
          if (enable) ms = 1;
        end
        1: begin
          if (!enable) begin
            ms = 0; mc = 0;
            if (ok) md = int'(cfg_div);
          end else begin
            mc = (mc == md - 1) ? 0 : mc + 1;
            if (ok) begin mp = int'(cfg_div); ms = 2; end
          end
        end
        default: begin
          if (!enable) begin
            ms = 0; mc = 0; md = mp;
          end else if (mc == md - 1) begin
            mc = 0; md = mp; ms = 1;
          end else begin
            mc = mc + 1;
          end
        end
      endcase
    end
    run = (ms != 0);
    sb.push_back({run, (ms != 2), me, run && (mc == md - 1), run && (mc < md / 2), 8'(md)});
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd9;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = sb.pop_front(); got = obs(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL reset_sb got=%h want=%h", got, exp_v);
      end
      checks++;
      if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2}) begin
        errors++; $display("FAIL reset_vals got=%h want=%h", got, {5'b01000, 8'd2});
      end
    end
    cfg_valid = 1'b0; enable = 1'b0;
  endtask

  task automatic test_div2();
    logic [1:0] want;
    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_v = sb.pop_front(); got = obs(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL div2_sb cyc=%0d got=%h want=%h", i, got, exp_v);
      end
      want[1] = (i % 2 == 1);
      want[0] = (i % 2 == 0);
      checks++;
      if (got[9:8] !== want) begin
        errors++; $display("FAIL div2_wave cyc=%0d tick_div=%b want=%b", i, got[9:8], want);
      end
    end
  endtask

  task automatic test_cfg_idle();
    int ticks, highs;
    ticks = 0; highs = 0;
    for (int i = 0; i < 22; i++) begin
      enable    = (i >= 2);
      cfg_valid = (i == 1);
      cfg_div   = 8'd5;
      step();
      exp_v = sb.pop_front(); got = obs(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL cfg_idle_sb cyc=%0d got=%h want=%h", i, got, exp_v);
      end
      if (i == 1) begin
        checks++;
        if (got[7:0] !== 8'd5 || got[12] !== 1'b0) begin
          errors++; $display("FAIL cfg_idle_commit cur_div=%0d run=%b want 5/0", got[7:0], got[12]);
        end
      end
      if (i >= 2) begin
        ticks += int'(got[9]);
        highs += int'(got[8]);
      end
    end
    checks++;
    if (ticks !== 4 || highs !== 8) begin
      errors++; $display("FAIL cfg_idle_period ticks=%0d highs=%0d want 4/8", ticks, highs);
    end
  endtask

  task automatic test_pend();
    int ticks;
    ticks = 0;
    for (int i = 0; i < 19; i++) begin
      enable    = (i >= 2);
      cfg_valid = (i == 1 || i == 4);
      cfg_div   = (i == 1) ? 8'd4 : 8'd6;
      step();
      exp_v = sb.pop_front(); got = obs(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL pend_sb cyc=%0d got=%h want=%h", i, got, exp_v);
      end
      cfg_valid = 1'b0;
      if (i == 4) begin
        checks++;
        if (got[11] !== 1'b0 || got[7:0] !== 8'd4) begin
          errors++; $display("FAIL pend_hold ready=%b cur_div=%0d want 0/4", got[11], got[7:0]);
        end
      end
      if (i == 5) begin
        checks++;
        if (got[9] !== 1'b1 || got[7:0] !== 8'd4) begin
          errors++; $display("FAIL pend_finish tick=%b cur_div=%0d want 1/4", got[9], got[7:0]);
        end
      end
      if (i == 6) begin
        checks++;
        if (got[11] !== 1'b1 || got[7:0] !== 8'd6) begin
          errors++; $display("FAIL pend_commit ready=%b cur_div=%0d want 1/6", got[11], got[7:0]);
        end
      end
      if (i >= 7) ticks += int'(got[9]);
    end
    checks++;
    if (ticks !== 2) begin
      errors++; $display("FAIL pend_period ticks=%0d want 2", ticks);
    end
  endtask

  task automatic test_illegal();
    int errs;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      enable    = 1'b1;
      cfg_valid = (i == 0 || i == 3);
      cfg_div   = (i == 0) ? 8'd1 : 8'd0;
      step();
      exp_v = sb.pop_front(); got = obs(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL illegal_sb cyc=%0d got=%h want=%h", i, got, exp_v);
      end
      checks++;
      if (got[10] !== (i == 0 || i == 3) || got[7:0] !== 8'd6 || got[12:11] !== 2'b11) begin
        errors++; $display("FAIL illegal_state cyc=%0d got=%h", i, got);
      end
      errs += int'(got[10]);
    end
    checks++;
    if (errs !== 2) begin
      errors++; $display("FAIL illegal_pulses count=%0d want 2", errs);
    end
  endtask

  task automatic test_drop_pend();
    int ticks;
    ticks = 0;
    for (int i = 0; i < 15; i++) begin
      enable    = !(i == 0 || i == 1 || i == 5);
      cfg_valid = (i == 1 || i == 3);
      cfg_div   = (i == 1) ? 8'd8 : 8'd3;
      step();
      exp_v = sb.pop_front(); got = obs(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL drop_sb cyc=%0d got=%h want=%h", i, got, exp_v);
      end
      if (i == 4) begin
        checks++;
        if (got[11] !== 1'b0 || got[7:0] !== 8'd8 || got[8] !== 1'b1) begin
          errors++; $display("FAIL drop_pend_state got=%h", got);
        end
      end
      if (i == 5) begin
        checks++;
        if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3}) begin
          errors++; $display("FAIL drop_idle got=%h want=%h", got, {5'b01000, 8'd3});
        end
      end
      if (i >= 6) ticks += int'(got[9]);
    end
    checks++;
    if (ticks !== 3) begin
      errors++; $display("FAIL drop_period ticks=%0d want 3", ticks);
    end
  endtask

  task automatic test_reset_mid();
    int ticks;
    ticks = 0;
    for (int i = 0; i < 14; i++) begin
      reset     = (i == 7);
      enable    = (i >= 2);
      cfg_valid = (i == 1 || i == 3 || i == 7);
      cfg_div   = (i == 1) ? 8'd10 : ((i == 3) ? 8'd7 : 8'd9);
      step();
      exp_v = sb.pop_front(); got = obs(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL rstmid_sb cyc=%0d got=%h want=%h", i, got, exp_v);
      end
      if (i == 6) begin
        checks++;
        if (got[7:0] !== 8'd10 || got[8] !== 1'b1 || got[11] !== 1'b0) begin
          errors++; $display("FAIL rstmid_pre got=%h", got);
        end
      end
      if (i == 7) begin
        checks++;
        if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2}) begin
          errors++; $display("FAIL rstmid_vals got=%h want=%h", got, {5'b01000, 8'd2});
        end
      end
      if (i >= 8) begin
        ticks += int'(got[9]);
        checks++;
        if (got[7:0] !== 8'd2) begin
          errors++; $display("FAIL rstmid_div cyc=%0d cur_div=%0d want 2", i, got[7:0]);
        end
      end
    end
    checks++;
    if (ticks !== 3) begin
      errors++; $display("FAIL rstmid_period ticks=%0d want 3", ticks);
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_cfg_idle();
    test_pend();
    test_illegal();
    test_drop_pend();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_div_controller.md
CLOCK_DIV_CONTROLLER -- requirements
Module: clock_div_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the divisor and counter width in bits.
REQ-002 The block SHALL have parameter RESET_DIV, default 2, which sets the divisor loaded at reset (legal range 2..2^WIDTH-1).
REQ-003 clock  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  run request: high = divide, low = stop.
REQ-006 cfg_valid  input  1  new divisor offered.
REQ-007 cfg_div  input  WIDTH  offered divisor value.
REQ-008 cfg_ready  output  1  controller can accept a divisor this cycle.
REQ-009 cfg_err  output  1  one-cycle pulse: the last accepted divisor was illegal.
REQ-010 tick  output  1  one-cycle enable pulse, once per divided period.
REQ-011 div_out  output  1  divided square wave.
REQ-012 running  output  1  high in RUN or PEND.
REQ-013 cur_div  output  WIDTH  divisor currently in effect.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and PEND.
REQ-015 A configuration handshake SHALL complete on any rising edge where cfg_valid and cfg_ready are both high.
REQ-016 cfg_ready SHALL be high in IDLE and RUN and low in PEND.
REQ-017 A divisor below 2 SHALL be illegal; when accepted, it SHALL leave cur_div and the FSM state unchanged and assert cfg_err in the following cycle only.
REQ-018 A legal divisor accepted in IDLE SHALL take effect on cur_div in the next cycle.
REQ-019 A legal divisor accepted in RUN SHALL be stored in a pending register and SHALL move the FSM to PEND.
REQ-020 In PEND, at the period end (cnt == cur_div-1), the block SHALL load the pending value into cur_div, reset cnt to 0, and return to RUN; the current period is never truncated.
REQ-021 The transition IDLE -> RUN SHALL occur on the edge where enable is sampled high, with cnt = 0 in the first RUN cycle.
REQ-022 In RUN and PEND, cnt SHALL increment by 1 per cycle and wrap from cur_div-1 to 0.
REQ-023 tick SHALL be high exactly when running and cnt == cur_div-1, giving the first tick in the cur_div-th RUN cycle.
REQ-024 div_out SHALL be high exactly when running and cnt < (cur_div >> 1): 50% duty for even divisors, low-biased for odd divisors; divisor 2 toggles every cycle.
REQ-025 tick and div_out SHALL be decoded only from registered state, with no combinational path from any input.
REQ-026 If enable is sampled low in RUN or PEND, the block SHALL enter IDLE on the next edge with cnt = 0, tick = 0 and div_out = 0.
REQ-027 When leaving PEND because enable is low, any pending divisor SHALL be committed to cur_div at the same edge.
REQ-028 If enable is low and a legal handshake occurs in the same cycle in RUN, the new divisor SHALL commit directly and the FSM SHALL go to IDLE.
REQ-029 The arithmetic SHALL be unsigned WIDTH-bit, with no overflow possible because cnt < cur_div <= 2^WIDTH-1.

Reset
REQ-030 While reset is high, the block SHALL force: state = IDLE, cnt = 0, cur_div = RESET_DIV, pending register = 0, cfg_err = 0.
REQ-031 Resulting outputs during reset SHALL be: tick = 0, div_out = 0, running = 0, cfg_ready = 1.
REQ-032 Reset SHALL take priority over enable and the configuration handshake.
REQ-033 Reset asserted mid-period SHALL discard both the partial period and any pending divisor.

Structure
REQ-034 A shared package SHALL hold the FSM state enumeration (IDLE/RUN/PEND) and the constant MIN_DIV = 2.
REQ-035 The block SHALL contain one sub-module, div_counter, holding cnt with wrap, synchronous clear and terminal-count output; the FSM and handshake logic SHALL stay in the top level.

Verification
REQ-036 Reset, then enable=1 with RESET_DIV=2 -> div_out toggles every cycle and tick is high on every 2nd RUN cycle.
REQ-037 In IDLE, cfg_div=5 with cfg_valid=1 for one cycle, then enable=1 -> cur_div=5, tick every 5 cycles, div_out high 2 of every 5 cycles.
REQ-038 In RUN with div=4 and cnt=1, offer cfg_div=6 -> cfg_ready goes low, the period completes at cnt=3, then 6-cycle periods follow and cfg_ready returns high.
REQ-039 Offer cfg_div=1 and cfg_div=0 -> cfg_err pulses for exactly 1 cycle each, cur_div is unchanged, and there is no glitch on tick.
REQ-040 Drop enable at cnt=2 of div=8 while PEND holds 3 -> next cycle is IDLE with outputs 0 and cur_div=3; re-enable gives 3-cycle periods.
REQ-041 Assert reset at cnt=4 of div=10 -> all outputs reach their reset values on the next edge and cur_div=RESET_DIV.
